// File: rtl/tracker_sequencer_pkg.sv
// Shared definitions for the colour-tracking frame sequencer.
//   COORD_W        width of centroid / position coordinates
//   H_MAX_DEFAULT  default exclusive column bound of a legal centroid
//   V_MAX_DEFAULT  default exclusive row bound of a legal centroid
//   state_t        sequencer states; the encoding is visible on oState
package tracker_sequencer_pkg;

    localparam int COORD_W       = 16;
    localparam int H_MAX_DEFAULT = 640;
    localparam int V_MAX_DEFAULT = 480;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRACK   = 3'd1,
        ST_ARM     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_FROZEN  = 3'd4
    } state_t;

endpackage

// File: rtl/frame_edge_detect.sv
// Frame boundary decoder for the VGA vertical-active strobe.
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   vreq         vertical-active strobe, high during active lines
//   clear        drops the synced flag (sequencer idle / disabled)
//   frame_start  one-cycle pulse, rising edge of vreq
//   frame_end    one-cycle pulse, falling edge of vreq
//   synced       set by the first frame_start after clear / reset
module frame_edge_detect
    import tracker_sequencer_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic vreq,
    input  logic clear,
    output logic frame_start,
    output logic frame_end,
    output logic synced
);

    logic vreq_p0;
    logic vreq_d;

    // Both taps come out of reset high: a reset released in the middle of an
    // active frame must not look like a frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vreq_p0 <= 1'b1;
            vreq_d  <= 1'b1;
            synced  <= 1'b0;
        end else begin
            vreq_p0 <= vreq;
            vreq_d  <= vreq_p0;
            if (clear) begin
                synced <= 1'b0;
            end else if (frame_start) begin
                synced <= 1'b1;
            end
        end
    end

    assign frame_start = vreq_p0 & ~vreq_d;
    assign frame_end   = ~vreq_p0 & vreq_d;

endmodule

// File: rtl/tracker_sequencer.sv
// Frame-level controller for the colour-tracking path.
// Samples the detector centroid at every synced frame end, averages
// 2^AVG_LOG2 legal samples, offers the result over valid/ready, and
// sequences the detector RAM freeze for snapshots.
//   iVgaClk       pixel clock
//   reset_n       asynchronous active-low reset
//   iEnable       low forces IDLE
//   iVgaVRequest  vertical-active strobe
//   iCentroidCol  detector centroid column
//   iCentroidRow  detector centroid row
//   iSnapReq      one-cycle snapshot request / release
//   iPosReady     consumer ready
//   oPosValid     averaged position available
//   oPosCol       averaged column
//   oPosRow       averaged row
//   oFreezeRam    detector RAM write-freeze
//   oState        current state (debug)
//   oDropCount    saturating count of overwritten unconsumed results
module tracker_sequencer
    import tracker_sequencer_pkg::*;
#(
    parameter int AVG_LOG2    = 2,
    parameter int HOLD_FRAMES = 30,
    parameter int H_MAX       = H_MAX_DEFAULT,
    parameter int V_MAX       = V_MAX_DEFAULT
) (
    input  logic               iVgaClk,
    input  logic               reset_n,
    input  logic               iEnable,
    input  logic               iVgaVRequest,
    input  logic [COORD_W-1:0] iCentroidCol,
    input  logic [COORD_W-1:0] iCentroidRow,
    input  logic               iSnapReq,
    input  logic               iPosReady,
    output logic               oPosValid,
    output logic [COORD_W-1:0] oPosCol,
    output logic [COORD_W-1:0] oPosRow,
    output logic               oFreezeRam,
    output logic [2:0]         oState,
    output logic [7:0]         oDropCount
);

    localparam int                ACC_W  = COORD_W + AVG_LOG2;
    localparam int                N_W    = AVG_LOG2 + 1;
    localparam int                CMP_W  = COORD_W + 1;
    localparam logic [N_W-1:0]    N_LAST = N_W'((1 << AVG_LOG2) - 1);
    localparam logic [CMP_W-1:0]  H_LIM  = CMP_W'(H_MAX);
    localparam logic [CMP_W-1:0]  V_LIM  = CMP_W'(V_MAX);
    localparam logic [15:0]       HOLD_INIT       = 16'(HOLD_FRAMES);
    localparam bit                HOLD_UNTIL_SNAP = (HOLD_FRAMES == 0);

    // Truncating average of a full accumulator.
    function automatic logic [COORD_W-1:0] avg_of(input logic [ACC_W-1:0] sum);
        return COORD_W'(sum >> AVG_LOG2);
    endfunction

    // Drop counter increment, sticking at all-ones.
    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

    state_t           state;
    logic             snap_p0;
    logic             frame_start;
    logic             frame_end;
    logic             synced;
    logic             frame_end_s;
    logic             edge_clear;
    logic [ACC_W-1:0] acc_col;
    logic [ACC_W-1:0] acc_row;
    logic [ACC_W-1:0] sum_col;
    logic [ACC_W-1:0] sum_row;
    logic [N_W-1:0]   n;
    logic [15:0]      hold;
    logic             sample_en;
    logic             legal;
    logic             last_sample;
    logic             new_result;
    logic             transfer;

    assign edge_clear = (state == ST_IDLE) || !iEnable;

    frame_edge_detect u_edge (
        .clk         (iVgaClk),
        .rst_n       (reset_n),
        .vreq        (iVgaVRequest),
        .clear       (edge_clear),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .synced      (synced)
    );

    // Frame ends before the first full frame are partial and never sampled.
    assign frame_end_s = frame_end & synced;
    assign sample_en   = frame_end_s && (state != ST_IDLE);
    assign legal       = ({1'b0, iCentroidCol} < H_LIM) && ({1'b0, iCentroidRow} < V_LIM);
    assign last_sample = (n == N_LAST);
    assign new_result  = sample_en && legal && last_sample;
    assign transfer    = oPosValid && iPosReady;
    assign sum_col     = acc_col + ACC_W'(iCentroidCol);
    assign sum_row     = acc_row + ACC_W'(iCentroidRow);

    always_ff @(posedge iVgaClk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            snap_p0    <= 1'b0;
            acc_col    <= '0;
            acc_row    <= '0;
            n          <= '0;
            hold       <= '0;
            oPosValid  <= 1'b0;
            oPosCol    <= '0;
            oPosRow    <= '0;
            oFreezeRam <= 1'b0;
            oDropCount <= '0;
        end else begin
            // Snap is registered so it acts one edge after it is sampled.
            snap_p0 <= iSnapReq;
            if (!iEnable) begin
                // Position data is kept for the consumer; everything else drops.
                state      <= ST_IDLE;
                acc_col    <= '0;
                acc_row    <= '0;
                n          <= '0;
                oPosValid  <= 1'b0;
                oFreezeRam <= 1'b0;
            end else begin
                if (sample_en) begin
                    if (!legal || last_sample) begin
                        acc_col <= '0;
                        acc_row <= '0;
                        n       <= '0;
                    end else begin
                        acc_col <= sum_col;
                        acc_row <= sum_row;
                        n       <= n + N_W'(1);
                    end
                end

                // A result landing on a transfer cycle replaces the consumed
                // one and is not a drop.
                if (new_result) begin
                    oPosValid <= 1'b1;
                    oPosCol   <= avg_of(sum_col);
                    oPosRow   <= avg_of(sum_row);
                    if (oPosValid && !iPosReady) begin
                        oDropCount <= sat_inc(oDropCount);
                    end
                end else if (transfer) begin
                    oPosValid <= 1'b0;
                end

                case (state)
                    ST_IDLE: begin
                        state <= ST_TRACK;
                    end
                    ST_TRACK: begin
                        if (snap_p0) begin
                            state <= ST_ARM;
                        end
                    end
                    ST_ARM: begin
                        // Wait for a frame start so the RAM sees a whole frame.
                        if (frame_start) begin
                            state <= ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        if (frame_end_s) begin
                            state      <= ST_FROZEN;
                            oFreezeRam <= 1'b1;
                            hold       <= HOLD_INIT;
                        end
                    end
                    ST_FROZEN: begin
                        if (snap_p0) begin
                            state      <= ST_TRACK;
                            oFreezeRam <= 1'b0;
                        end else if (frame_end_s && !HOLD_UNTIL_SNAP) begin
                            if (hold <= 16'd1) begin
                                state      <= ST_TRACK;
                                oFreezeRam <= 1'b0;
                            end else begin
                                hold <= hold - 16'd1;
                            end
                        end
                    end
                    default: begin
                        state      <= ST_IDLE;
                        oFreezeRam <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign oState = state;

endmodule

// File: tb/tb_tracker_sequencer.sv
// Bench for tracker_sequencer: reset values, directed frame sequences,
// a vector table of averaging cases, and a randomized run compared every
// cycle against a frame-level reference model.
module tb_tracker_sequencer;

    localparam int AVG_LOG2 = 2;
    localparam int AVG_N    = 1 << AVG_LOG2;
    localparam int HOLD     = 3;
    localparam int H_MAX    = 640;
    localparam int V_MAX    = 480;
    localparam int ACT      = 6;
    localparam int BLANK    = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic        vreq;
    logic [15:0] col;
    logic [15:0] row;
    logic        snap;
    logic        rdy;

    logic        pv,  fz,  pv0, fz0;
    logic [15:0] pc,  pr,  pc0, pr0;
    logic [2:0]  st,  st0;
    logic [7:0]  dc,  dc0;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    tracker_sequencer #(.AVG_LOG2(AVG_LOG2), .HOLD_FRAMES(HOLD), .H_MAX(H_MAX), .V_MAX(V_MAX)) dut (
        .iVgaClk(clk), .reset_n(reset_n), .iEnable(en), .iVgaVRequest(vreq),
        .iCentroidCol(col), .iCentroidRow(row), .iSnapReq(snap), .iPosReady(rdy),
        .oPosValid(pv), .oPosCol(pc), .oPosRow(pr), .oFreezeRam(fz),
        .oState(st), .oDropCount(dc)
    );

    tracker_sequencer #(.AVG_LOG2(AVG_LOG2), .HOLD_FRAMES(0), .H_MAX(H_MAX), .V_MAX(V_MAX)) dut0 (
        .iVgaClk(clk), .reset_n(reset_n), .iEnable(en), .iVgaVRequest(vreq),
        .iCentroidCol(col), .iCentroidRow(row), .iSnapReq(snap), .iPosReady(rdy),
        .oPosValid(pv0), .oPosCol(pc0), .oPosRow(pr0), .oFreezeRam(fz0),
        .oState(st0), .oDropCount(dc0)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame-level rules) ----------------
    // Line history as seen at the last two clock edges, plus the snap request
    // seen at the last edge (requests act one edge after they are seen).
    bit m_h0, m_h1, m_sn, m_sync, m_valid, m_freeze;
    int m_state, m_hold, m_cnt, m_drops, m_sc, m_sr, m_pc, m_pr;

    task automatic model_reset();
        m_h0 = 1'b1; m_h1 = 1'b1; m_sn = 1'b0; m_sync = 1'b0;
        m_valid = 1'b0; m_freeze = 1'b0;
        m_state = 0; m_hold = 0; m_cnt = 0; m_drops = 0;
        m_sc = 0; m_sr = 0; m_pc = 0; m_pr = 0;
    endtask

    task automatic model_step();
        bit rise, fall, got;
        rise = m_h0 && !m_h1;
        fall = !m_h0 && m_h1 && m_sync;
        got  = 1'b0;
        if (!en) begin
            m_state = 0; m_valid = 0; m_freeze = 0;
            m_sc = 0; m_sr = 0; m_cnt = 0; m_sync = 0;
        end else if (m_state == 0) begin
            m_state = 1; m_sync = 0;
        end else begin
            if (rise) m_sync = 1;
            if (fall) begin
                if (int'(col) < H_MAX && int'(row) < V_MAX) begin
                    m_sc += int'(col); m_sr += int'(row); m_cnt++;
                    if (m_cnt == AVG_N) begin
                        got = 1'b1;
                        if (m_valid && !rdy && m_drops < 255) m_drops++;
                        m_pc = m_sc / AVG_N; m_pr = m_sr / AVG_N;
                        m_sc = 0; m_sr = 0; m_cnt = 0;
                    end
                end else begin
                    m_sc = 0; m_sr = 0; m_cnt = 0;
                end
            end
            if (got) m_valid = 1;
            else if (m_valid && rdy) m_valid = 0;
            case (m_state)
                1: if (m_sn) m_state = 2;
                2: if (rise) m_state = 3;
                3: if (fall) begin m_state = 4; m_freeze = 1; m_hold = HOLD; end
                4: begin
                    if (m_sn) begin m_state = 1; m_freeze = 0; end
                    else if (fall) begin
                        if (m_hold <= 1) begin m_state = 1; m_freeze = 0; end
                        else m_hold--;
                    end
                end
                default: m_state = 0;
            endcase
        end
        m_h1 = m_h0; m_h0 = vreq; m_sn = snap;
    endtask

    always @(posedge clk) if (reset_n) model_step();

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_valid",  int'(pv), int'(m_valid));
            chk("model_col",    int'(pc), m_pc);
            chk("model_row",    int'(pr), m_pr);
            chk("model_freeze", int'(fz), int'(m_freeze));
            chk("model_state",  int'(st), m_state);
            chk("model_drops",  int'(dc), m_drops);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic vreq_up();
        vreq = 1'b1; step(1);
    endtask

    task automatic vreq_down(input int c, input int r);
        col = 16'(c); row = 16'(r); vreq = 1'b0; step(1);
    endtask

    task automatic frame(input int c, input int r);
        vreq_up(); step(ACT - 1);
        vreq_down(c, r); step(BLANK - 1);
    endtask

    task automatic consume();
        rdy = 1'b1; step(1); rdy = 1'b0;
    endtask

    typedef struct {
        int c; int stp; int r; bit exp_v; int exp_c; int exp_r;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{c: 10,  stp: 0, r: 20,  exp_v: 1'b1, exp_c: 10,  exp_r: 20};
        tbl[1] = '{c: 1,   stp: 1, r: 7,   exp_v: 1'b1, exp_c: 2,   exp_r: 7};
        tbl[2] = '{c: 639, stp: 0, r: 479, exp_v: 1'b1, exp_c: 639, exp_r: 479};
        tbl[3] = '{c: 640, stp: 0, r: 0,   exp_v: 1'b0, exp_c: 0,   exp_r: 0};
        tbl[4] = '{c: 0,   stp: 0, r: 480, exp_v: 1'b0, exp_c: 0,   exp_r: 0};
        tbl[5] = '{c: 636, stp: 1, r: 0,   exp_v: 1'b1, exp_c: 637, exp_r: 0};

        // Reset asserted while the line is already active.
        reset_n = 1'b0; en = 1'b0; vreq = 1'b1; col = '0; row = '0;
        snap = 1'b0; rdy = 1'b0;
        model_reset();
        chk_en = 1'b1;
        step(3);
        chk("rst_valid", int'(pv), 0);
        chk("rst_col",   int'(pc), 0);
        chk("rst_row",   int'(pr), 0);
        chk("rst_freeze", int'(fz), 0);
        chk("rst_state", int'(st), 0);
        chk("rst_drops", int'(dc), 0);

        // Partial frame then four averaged frames.
        reset_n = 1'b1; en = 1'b1;
        step(3);
        vreq_down(500, 5); step(BLANK - 1);
        chk("track_after_enable", int'(st), 1);
        frame(100, 50); frame(102, 50); frame(104, 50);
        chk("partial_ignored_valid", int'(pv), 0);
        frame(106, 50);
        chk("avg_valid", int'(pv), 1);
        chk("avg_col",   int'(pc), 103);
        chk("avg_row",   int'(pr), 50);
        consume();
        chk("avg_consumed", int'(pv), 0);

        // Vector table: four frames per entry.
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < AVG_N; j++) frame(tbl[i].c + j * tbl[i].stp, tbl[i].r);
            chk($sformatf("tbl%0d_valid", i), int'(pv), int'(tbl[i].exp_v));
            if (tbl[i].exp_v) begin
                chk($sformatf("tbl%0d_col", i), int'(pc), tbl[i].exp_c);
                chk($sformatf("tbl%0d_row", i), int'(pr), tbl[i].exp_r);
            end
            consume();
        end

        // Illegal sample clears the running average.
        frame(200, 10); frame(200, 10); frame(700, 10);
        frame(200, 10); frame(200, 10); frame(200, 10);
        chk("illegal_not_yet", int'(pv), 0);
        frame(200, 10);
        chk("illegal_valid", int'(pv), 1);
        chk("illegal_col",   int'(pc), 200);
        consume();

        // Three results with nobody ready: two drops, latest data kept.
        for (int p = 1; p <= 3; p++)
            for (int j = 0; j < AVG_N; j++) frame(10 * p, 5);
        chk("drop_valid", int'(pv), 1);
        chk("drop_col",   int'(pc), 30);
        chk("drop_count", int'(dc), 2);
        // Fourth result lands exactly on a transfer cycle.
        for (int j = 0; j < AVG_N - 1; j++) frame(40, 5);
        vreq_up(); step(ACT - 1);
        vreq_down(40, 5);
        rdy = 1'b1; step(1); rdy = 1'b0;
        chk("xfer_new_valid", int'(pv), 1);
        chk("xfer_new_col",   int'(pc), 40);
        chk("xfer_no_drop",   int'(dc), 2);
        step(BLANK - 2);
        consume();

        // Snapshot with a three-frame hold.
        rdy = 1'b1;
        vreq_up(); step(2);
        snap = 1'b1; step(1); snap = 1'b0;
        chk("snap_seen_state", int'(st), 1);
        step(1);
        chk("snap_arm", int'(st), 2);
        step(ACT - 4);
        vreq_down(300, 40);
        chk("arm_after_fall", int'(st), 2);
        step(BLANK - 1);
        vreq_up();
        chk("arm_at_rise", int'(st), 2);
        step(1);
        chk("capture", int'(st), 3);
        step(ACT - 2);
        vreq_down(300, 40);
        chk("freeze_not_yet", int'(fz), 0);
        step(1);
        chk("freeze_set", int'(fz), 1);
        chk("frozen_state", int'(st), 4);
        step(BLANK - 2);
        frame(300, 40); frame(300, 40);
        chk("freeze_held", int'(fz), 1);
        vreq_up(); step(ACT - 1);
        vreq_down(300, 40);
        chk("freeze_last_frame", int'(fz), 1);
        step(1);
        chk("freeze_released", int'(fz), 0);
        chk("back_to_track", int'(st), 1);
        step(BLANK - 2);

        // Hold-until-snap instance: frozen for ten more frames.
        rdy = 1'b0;
        for (int j = 0; j < 10; j++) frame(320, 240);
        chk("hold0_frozen", int'(fz0), 1);
        chk("hold0_state",  int'(st0), 4);
        snap = 1'b1; step(1); snap = 1'b0;
        chk("hold0_release_wait", int'(fz0), 1);
        step(1);
        chk("hold0_released", int'(fz0), 0);
        chk("hold0_track", int'(st0), 1);
        chk("snap_rearm", int'(st), 2);

        // Abort from FROZEN by disabling.
        frame(320, 240);
        chk("abort_pre_frozen", int'(st), 4);
        chk("abort_pre_valid", int'(pv), 1);
        en = 1'b0; step(1);
        chk("abort_state",  int'(st), 0);
        chk("abort_freeze", int'(fz), 0);
        chk("abort_valid",  int'(pv), 0);
        en = 1'b1; step(2);

        // Randomized run against the model.
        for (int f = 0; f < 300; f++) begin
            int act_len, blk_len;
            act_len = $urandom_range(3, 10);
            blk_len = $urandom_range(2, 6);
            vreq = 1'b1;
            for (int c = 0; c < act_len; c++) begin
                rdy  = (f % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
                snap = ($urandom_range(0, 29) == 0);
                en   = ($urandom_range(0, 249) != 0);
                step(1);
            end
            col  = 16'($urandom_range(0, 699));
            row  = 16'($urandom_range(0, 519));
            vreq = 1'b0;
            for (int c = 0; c < blk_len; c++) begin
                rdy  = (f % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
                snap = ($urandom_range(0, 29) == 0);
                en   = ($urandom_range(0, 249) != 0);
                step(1);
            end
        end
        snap = 1'b0; en = 1'b1;
        step(2);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tracker_sequencer.md
# tracker_sequencer

Frame-level controller for the colour-tracking path. It watches the VGA vertical-active strobe and samples the detector's centroid once per frame. It averages 2^AVG_LOG2 consecutive frames and hands the result to game logic over a valid/ready handshake. It also sequences the detector's RAM freeze for on-demand snapshots, driving the `iFreezeRam` input of the ball detector.

## Interface
- AVG_LOG2, 2: log2 of frames averaged per output (0..4).
- HOLD_FRAMES, 30: frames a snapshot stays frozen; 0 = frozen until next snap request.
- H_MAX, 640 / V_MAX, 480: exclusive bounds for a legal centroid column / row.
- iVgaClk  in  1  pixel clock; sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- iEnable  in  1  level; low forces IDLE.
- iVgaVRequest  in  1  high during active frame lines.
- iCentroidCol  in  16  detector centroid column (compared against the horizontal index).
- iCentroidRow  in  16  detector centroid row.
- iSnapReq  in  1  single-cycle snapshot request / release.
- iPosReady  in  1  consumer ready.
- oPosValid  out  1  averaged position available.
- oPosCol, oPosRow  out  16  averaged position.
- oFreezeRam  out  1  to detector RAM write-freeze.
- oState  out  3  current state (debug).
- oDropCount  out  8  saturating count of overwritten unconsumed results.

## Operation
- Edge detect: `vreq_d` is `iVgaVRequest` delayed by one register. `frame_start` = rising edge of `iVgaVRequest`; `frame_end` = falling edge.
- `synced` flag:
  - Cleared by reset and in IDLE.
  - Set on the first `frame_start`.
  - A `frame_end` is ignored until `synced` is set, so partial frames after reset or enable are never sampled.
- Sample at each synced `frame_end` (all states except IDLE):
  - Legal sample (col < H_MAX and row < V_MAX): added to the accumulators and `n` increments.
  - Illegal sample: accumulators and `n` clear.
- Accumulators are 16+AVG_LOG2 bits. On the sample that brings `n` to 2^AVG_LOG2:
  - oPosCol / oPosRow = (sum + sample) >> AVG_LOG2, truncating.
  - oPosValid sets; accumulators and `n` clear.
- Handshake:
  - Transfer occurs when oPosValid and iPosReady are high on the same cycle; valid clears next cycle.
  - A new result arriving while valid is high overwrites the data and valid stays high.
  - oDropCount increments (saturating at 255) only if iPosReady was low on that cycle. A simultaneous transfer and new result is not a drop.
- State machine (oState encoding in parentheses):
  - IDLE (0): freeze low, valid low, accumulators clear. Goes to TRACK when iEnable is high.
  - TRACK (1): on iSnapReq, go to ARM.
  - ARM (2): on `frame_start`, go to CAPTURE, so the RAM receives one complete frame.
  - CAPTURE (3): on `frame_end`, go to FROZEN; oFreezeRam sets; hold counter loads HOLD_FRAMES.
  - FROZEN (4), per synced `frame_end`:
    - Hold counter > 1: decrement.
    - Hold counter == 1: go to TRACK, freeze clears.
    - HOLD_FRAMES = 0: no decrement; FROZEN holds until iSnapReq.
  - iSnapReq in FROZEN releases immediately to TRACK. iSnapReq in ARM or CAPTURE is ignored.
  - iEnable low in any state goes to IDLE on the next edge. Output data is retained; valid, freeze, synced and the accumulators clear.
- Averaging continues in ARM, CAPTURE and FROZEN.

## Timing
- All outputs are registered.
- Reset values: oPosValid 0, oPosCol 0, oPosRow 0, oFreezeRam 0, oState IDLE, oDropCount 0.
- iVgaVRequest falls, sampled low at edge k. Then `frame_end` is decoded in cycle k, and at edge k+1:
  - the centroid is sampled,
  - oPosValid / oPos* update,
  - state and oFreezeRam update.
- Rising edge sampled at k: CAPTURE is entered at edge k+1.
- iSnapReq sampled at edge k: the state changes at edge k+1.
- The centroid inputs must be stable in the cycle after iVgaVRequest falls.

## Structure
- Shared package:
  - state enum (IDLE/TRACK/ARM/CAPTURE/FROZEN, 3 bits),
  - H_MAX / V_MAX defaults of 640 / 480,
  - COORD_W = 16.
- One natural sub-module: `frame_edge_detect` (vreq_d register, `frame_start`/`frame_end`, `synced` flag).
- Averaging, handshake and the FSM stay in `tracker_sequencer`.

## Test plan
- Averaging: AVG_LOG2=2, four frames with col 100,102,104,106 and row 50 each -> after the 4th fall, oPosValid=1, oPosCol=103, oPosRow=50; iPosReady=1 clears valid next cycle.
- Partial frame: reset released mid-frame with iVgaVRequest=1; the first fall is ignored -> oPosValid only after 4 further complete frames.
- Illegal sample: samples 200,200,700(col),200,200,200,200 -> the accumulator clears at 700; the result is 200 after 4 legal frames following the illegal one.
- Drop counting: iPosReady=0 over 3 result periods -> oPosValid stays 1, oPos holds the latest result, oDropCount=2. A new result coinciding with iPosReady=1 -> oDropCount unchanged.
- Snapshot: HOLD_FRAMES=3, iSnapReq mid-frame -> ARM until the next rise, CAPTURE for one full frame, oFreezeRam=1 at fall+1, clears at fall+1 of the 3rd following frame, oState returns to TRACK (1).
- Release and abort:
  - HOLD_FRAMES=0: freeze persists for 10 frames; iSnapReq -> oFreezeRam=0 next edge.
  - iEnable=0 during FROZEN -> oState=IDLE, oFreezeRam=0, oPosValid=0 next edge.
